lockstep_data_port: RTL and testbench



---
 rtl/lockstep_data_port_pkg.sv | 36 +++
 rtl/lockstep_data_port_if.sv | 50 +++++
 rtl/lockstep_data_port_req_capture.sv | 28 ++
 rtl/lockstep_data_port.sv | 170 +++++++++++++++++
 tb/tb_lockstep_data_port.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/lockstep_data_port_pkg.sv
// Shared types for the lockstep data-memory front end.
package ft_pkg;

    localparam int unsigned LSDP_AW = 32;
    localparam int unsigned LSDP_DW = 32;
    localparam int unsigned LSDP_BW = LSDP_DW / 8;

    typedef enum logic [2:0] {
        LSDP_IDLE  = 3'd0,
        LSDP_HOLD  = 3'd1,
        LSDP_CMP   = 3'd2,
        LSDP_ISSUE = 3'd3,
        LSDP_RESP  = 3'd4,
        LSDP_ERROR = 3'd5
    } lsdp_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE  = 2'd0,
        CAUSE_FIELD = 2'd1,
        CAUSE_SKEW  = 2'd2
    } lsdp_cause_e;

    typedef struct packed {
        logic               we;
        logic [LSDP_BW-1:0] be;
        logic [LSDP_AW-1:0] addr;
        logic [LSDP_DW-1:0] wdata;
    } lsdp_req_t;

    // Write data only matters for stores; loads may carry stale wdata.
    function automatic logic lsdp_req_match(input lsdp_req_t a, input lsdp_req_t b);
        return (a.we == b.we) && (a.be == b.be) && (a.addr == b.addr) &&
               (!a.we || (a.wdata == b.wdata));
    endfunction

endpackage

// File: rtl/lockstep_data_port_if.sv
// Core-pair, memory and fault-status signals of the lockstep data port.
interface lockstep_data_port_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 8
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    logic                  a_req_i,   b_req_i;
    logic                  a_we_i,    b_we_i;
    logic [BE_WIDTH-1:0]   a_be_i,    b_be_i;
    logic [ADDR_WIDTH-1:0] a_addr_i,  b_addr_i;
    logic [DATA_WIDTH-1:0] a_wdata_i, b_wdata_i;
    logic                  a_gnt_o,   b_gnt_o;
    logic                  a_rvalid_o, b_rvalid_o;
    logic [DATA_WIDTH-1:0] rdata_o;

    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [BE_WIDTH-1:0]   mem_be_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic                  mem_gnt_i;
    logic                  mem_rvalid_i;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    logic                  clear_i;
    logic                  mismatch_o;
    logic [1:0]            err_cause_o;
    logic [CNT_WIDTH-1:0]  err_count_o;

    modport slave (
        input  a_req_i, b_req_i, a_we_i, b_we_i, a_be_i, b_be_i,
               a_addr_i, b_addr_i, a_wdata_i, b_wdata_i,
               mem_gnt_i, mem_rvalid_i, mem_rdata_i, clear_i,
        output a_gnt_o, b_gnt_o, a_rvalid_o, b_rvalid_o, rdata_o,
               mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
               mismatch_o, err_cause_o, err_count_o
    );

    modport master (
        output a_req_i, b_req_i, a_we_i, b_we_i, a_be_i, b_be_i,
               a_addr_i, b_addr_i, a_wdata_i, b_wdata_i,
               mem_gnt_i, mem_rvalid_i, mem_rdata_i, clear_i,
        input  a_gnt_o, b_gnt_o, a_rvalid_o, b_rvalid_o, rdata_o,
               mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
               mismatch_o, err_cause_o, err_count_o
    );

endinterface

// File: rtl/lockstep_data_port_req_capture.sv
// Holding register for one core's request, with a captured flag.
module lsdp_req_capture
    import ft_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      load,
    input  logic      flush,
    input  lsdp_req_t d,
    output lsdp_req_t q,
    output logic      captured
);

    // Load takes priority; flush drops the request once it is retired or discarded.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q        <= '0;
            captured <= 1'b0;
        end else if (load) begin
            q        <= d;
            captured <= 1'b1;
        end else if (flush) begin
            q        <= '0;
            captured <= 1'b0;
        end
    end

endmodule

// File: rtl/lockstep_data_port.sv
// Lockstep data-memory front end: pairs, compares and forwards core requests.
module lockstep_data_port
    import ft_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SKEW_MAX   = 4,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    lockstep_data_port_if.slave  bus
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned SKEW_W   = $clog2(SKEW_MAX + 1);

    lsdp_state_e           state, state_next;
    lsdp_cause_e           cause_next, cause_q;
    logic [SKEW_W-1:0]     skew_cnt, skew_cnt_next;
    lsdp_req_t             req_a_d, req_b_d, cap_a, cap_b;
    logic                  cap_a_vld, cap_b_vld;
    logic                  load_a, load_b, flush;
    logic                  a_gnt_c, b_gnt_c, rvalid_c;
    logic [DATA_WIDTH-1:0] rdata_c;

    logic                  mem_req_q, mem_we_q, mismatch_q;
    logic [BE_WIDTH-1:0]   mem_be_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic [CNT_WIDTH-1:0]  err_count_q;

    assign req_a_d = '{we: bus.a_we_i, be: LSDP_BW'(bus.a_be_i),
                       addr: LSDP_AW'(bus.a_addr_i), wdata: LSDP_DW'(bus.a_wdata_i)};
    assign req_b_d = '{we: bus.b_we_i, be: LSDP_BW'(bus.b_be_i),
                       addr: LSDP_AW'(bus.b_addr_i), wdata: LSDP_DW'(bus.b_wdata_i)};

    lsdp_req_capture u_cap_a (
        .clk_i(clk_i), .rst_i(rst_i), .load(load_a), .flush(flush),
        .d(req_a_d), .q(cap_a), .captured(cap_a_vld)
    );

    lsdp_req_capture u_cap_b (
        .clk_i(clk_i), .rst_i(rst_i), .load(load_b), .flush(flush),
        .d(req_b_d), .q(cap_b), .captured(cap_b_vld)
    );

    // State and skew counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= LSDP_IDLE;
            skew_cnt <= '0;
        end else begin
            state    <= state_next;
            skew_cnt <= skew_cnt_next;
        end
    end

    // Next state, capture control and combinational core-side outputs.
    always_comb begin
        state_next    = state;
        skew_cnt_next = skew_cnt;
        cause_next    = CAUSE_NONE;
        load_a        = 1'b0;
        load_b        = 1'b0;
        flush         = 1'b0;
        a_gnt_c       = 1'b0;
        b_gnt_c       = 1'b0;
        rvalid_c      = 1'b0;
        rdata_c       = '0;
        case (state)
            LSDP_IDLE: begin
                a_gnt_c = bus.a_req_i;
                b_gnt_c = bus.b_req_i;
                load_a  = bus.a_req_i;
                load_b  = bus.b_req_i;
                if (bus.a_req_i && bus.b_req_i) begin
                    state_next = LSDP_CMP;
                end else if (bus.a_req_i || bus.b_req_i) begin
                    skew_cnt_next = '0;
                    state_next    = LSDP_HOLD;
                end
            end
            LSDP_HOLD: begin
                a_gnt_c = bus.a_req_i && !cap_a_vld;
                b_gnt_c = bus.b_req_i && !cap_b_vld;
                load_a  = a_gnt_c;
                load_b  = b_gnt_c;
                if (a_gnt_c || b_gnt_c) begin
                    state_next = LSDP_CMP;
                end else begin
                    skew_cnt_next = skew_cnt + SKEW_W'(1);
                    if (skew_cnt_next == SKEW_W'(SKEW_MAX)) begin
                        cause_next = CAUSE_SKEW;
                        flush      = 1'b1;
                        state_next = LSDP_ERROR;
                    end
                end
            end
            LSDP_CMP: begin
                if (lsdp_req_match(cap_a, cap_b)) begin
                    state_next = LSDP_ISSUE;
                end else begin
                    cause_next = CAUSE_FIELD;
                    flush      = 1'b1;
                    state_next = LSDP_ERROR;
                end
            end
            LSDP_ISSUE: begin
                if (bus.mem_gnt_i) state_next = LSDP_RESP;
            end
            LSDP_RESP: begin
                if (bus.mem_rvalid_i) begin
                    rvalid_c   = 1'b1;
                    rdata_c    = bus.mem_rdata_i;
                    flush      = 1'b1;
                    state_next = LSDP_IDLE;
                end
            end
            LSDP_ERROR: begin
                if (bus.clear_i) state_next = LSDP_IDLE;
            end
            default: state_next = LSDP_IDLE;
        endcase
    end

    // Registered memory request and fault status.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mismatch_q  <= 1'b0;
            cause_q     <= CAUSE_NONE;
            err_count_q <= '0;
        end else begin
            mem_req_q  <= (state_next == LSDP_ISSUE);
            mismatch_q <= (state_next == LSDP_ERROR);
            if (state == LSDP_CMP && state_next == LSDP_ISSUE) begin
                mem_we_q    <= cap_a.we;
                mem_be_q    <= BE_WIDTH'(cap_a.be);
                mem_addr_q  <= ADDR_WIDTH'(cap_a.addr);
                mem_wdata_q <= DATA_WIDTH'(cap_a.wdata);
            end
            if (state_next == LSDP_ERROR && state != LSDP_ERROR) begin
                cause_q <= cause_next;
                if (err_count_q != '1) err_count_q <= err_count_q + CNT_WIDTH'(1);
            end else if (state_next != LSDP_ERROR) begin
                cause_q <= CAUSE_NONE;
            end
        end
    end

    assign bus.a_gnt_o     = a_gnt_c;
    assign bus.b_gnt_o     = b_gnt_c;
    assign bus.a_rvalid_o  = rvalid_c;
    assign bus.b_rvalid_o  = rvalid_c;
    assign bus.rdata_o     = rdata_c;
    assign bus.mem_req_o   = mem_req_q;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_be_o    = mem_be_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;
    assign bus.mismatch_o  = mismatch_q;
    assign bus.err_cause_o = cause_q;
    assign bus.err_count_o = err_count_q;

endmodule

// File: tb/tb_lockstep_data_port.sv
// Directed, table-driven bench for lockstep_data_port.
module tb_lockstep_data_port;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   wr_count = 0;
    int   exp_cnt = 0;

    always #5 clk = ~clk;

    lockstep_data_port_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(8)) bus ();

    lockstep_data_port #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SKEW_MAX(4), .CNT_WIDTH(8)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus)
    );

    typedef struct {
        logic        a_we;
        logic [3:0]  a_be;
        logic [31:0] a_addr;
        logic [31:0] a_wdata;
        logic        b_we;
        logic [3:0]  b_be;
        logic [31:0] b_addr;
        logic [31:0] b_wdata;
        int          skew;
        int          gnt_wait;
        logic [31:0] rdata;
        bit          exp_err;
    } vec_t;

    vec_t vecs[10];

    // Accepted stores as seen by memory.
    always @(posedge clk) begin
        if (bus.mem_req_o && bus.mem_gnt_i && bus.mem_we_o) wr_count <= wr_count + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_a(input vec_t v);
        bus.a_req_i = 1'b1; bus.a_we_i = v.a_we; bus.a_be_i = v.a_be;
        bus.a_addr_i = v.a_addr; bus.a_wdata_i = v.a_wdata;
    endtask

    task automatic drive_b(input vec_t v);
        bus.b_req_i = 1'b1; bus.b_we_i = v.b_we; bus.b_be_i = v.b_be;
        bus.b_addr_i = v.b_addr; bus.b_wdata_i = v.b_wdata;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int wr0;
        wr0 = wr_count;
        @(negedge clk);
        drive_a(v);
        if (v.skew == 0) drive_b(v);
        #1;
        chk($sformatf("v%0d gnt_a", idx), 64'(bus.a_gnt_o), 64'd1);
        chk($sformatf("v%0d gnt_b", idx), 64'(bus.b_gnt_o), 64'(v.skew == 0));
        for (int k = 1; k <= v.skew; k++) begin
            @(negedge clk);
            bus.a_req_i = 1'b0;
            if (k == v.skew) drive_b(v);
            #1;
            chk($sformatf("v%0d hold_gnt_a", idx), 64'(bus.a_gnt_o), 64'd0);
            chk($sformatf("v%0d hold_gnt_b", idx), 64'(bus.b_gnt_o), 64'(k == v.skew));
            chk($sformatf("v%0d hold_mismatch", idx), 64'(bus.mismatch_o), 64'd0);
        end
        @(negedge clk);
        bus.a_req_i = 1'b0; bus.b_req_i = 1'b0;
        #1 chk($sformatf("v%0d cmp_memreq", idx), 64'(bus.mem_req_o), 64'd0);
        @(negedge clk);
        if (!v.exp_err) begin
            chk($sformatf("v%0d mem_req", idx), 64'(bus.mem_req_o), 64'd1);
            chk($sformatf("v%0d mem_addr", idx), 64'(bus.mem_addr_o), 64'(v.a_addr));
            chk($sformatf("v%0d mem_we", idx), 64'(bus.mem_we_o), 64'(v.a_we));
            chk($sformatf("v%0d mem_be", idx), 64'(bus.mem_be_o), 64'(v.a_be));
            if (v.a_we) chk($sformatf("v%0d mem_wdata", idx), 64'(bus.mem_wdata_o), 64'(v.a_wdata));
            for (int w = 0; w < v.gnt_wait; w++) begin
                @(negedge clk);
                chk($sformatf("v%0d mem_req_wait", idx), 64'(bus.mem_req_o), 64'd1);
            end
            bus.mem_gnt_i = 1'b1;
            @(negedge clk);
            bus.mem_gnt_i = 1'b0;
            chk($sformatf("v%0d resp_memreq", idx), 64'(bus.mem_req_o), 64'd0);
            bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = v.rdata;
            #1;
            chk($sformatf("v%0d rvalid_a", idx), 64'(bus.a_rvalid_o), 64'd1);
            chk($sformatf("v%0d rvalid_b", idx), 64'(bus.b_rvalid_o), 64'd1);
            chk($sformatf("v%0d rdata", idx), 64'(bus.rdata_o), 64'(v.rdata));
            chk($sformatf("v%0d mismatch", idx), 64'(bus.mismatch_o), 64'd0);
            @(negedge clk);
            bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;
            #1 chk($sformatf("v%0d rvalid_done", idx), 64'(bus.a_rvalid_o), 64'd0);
            chk($sformatf("v%0d writes", idx), 64'(wr_count), 64'(wr0 + (v.a_we ? 1 : 0)));
        end else begin
            if (exp_cnt < 255) exp_cnt++;
            chk($sformatf("v%0d err_mismatch", idx), 64'(bus.mismatch_o), 64'd1);
            chk($sformatf("v%0d err_cause", idx), 64'(bus.err_cause_o), 64'd1);
            chk($sformatf("v%0d err_count", idx), 64'(bus.err_count_o), 64'(exp_cnt));
            chk($sformatf("v%0d err_memreq", idx), 64'(bus.mem_req_o), 64'd0);
            bus.a_req_i = 1'b1;
            #1 chk($sformatf("v%0d err_gnt", idx), 64'(bus.a_gnt_o), 64'd0);
            bus.a_req_i = 1'b0;
            bus.clear_i = 1'b1;
            @(negedge clk);
            bus.clear_i = 1'b0;
            #1;
            chk($sformatf("v%0d clr_mismatch", idx), 64'(bus.mismatch_o), 64'd0);
            chk($sformatf("v%0d clr_cause", idx), 64'(bus.err_cause_o), 64'd0);
            chk($sformatf("v%0d clr_count", idx), 64'(bus.err_count_o), 64'(exp_cnt));
            chk($sformatf("v%0d no_write", idx), 64'(wr_count), 64'(wr0));
        end
    endtask

    initial begin
        bus.a_req_i = 0; bus.b_req_i = 0; bus.a_we_i = 0; bus.b_we_i = 0;
        bus.a_be_i = 0; bus.b_be_i = 0; bus.a_addr_i = 0; bus.b_addr_i = 0;
        bus.a_wdata_i = 0; bus.b_wdata_i = 0; bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0;
        bus.mem_rdata_i = 0; bus.clear_i = 0;

        //          a_we  a_be   a_addr        a_wdata       b_we  b_be   b_addr        b_wdata       skew gw rdata          err
        vecs[0] = '{1'b0, 4'hF, 32'h0000_0100, 32'h0,        1'b0, 4'hF, 32'h0000_0100, 32'h0,        0, 0, 32'hDEAD_BEEF, 1'b0};
        vecs[1] = '{1'b0, 4'hF, 32'h0000_0200, 32'h0,        1'b0, 4'hF, 32'h0000_0200, 32'h0,        3, 0, 32'h1234_5678, 1'b0};
        vecs[2] = '{1'b0, 4'h3, 32'h0000_0204, 32'h0,        1'b0, 4'h3, 32'h0000_0204, 32'h0,        4, 0, 32'h0000_ABCD, 1'b0};
        vecs[3] = '{1'b1, 4'hF, 32'h0000_0300, 32'h0000_0055, 1'b1, 4'hF, 32'h0000_0300, 32'h0000_0055, 0, 1, 32'h0,         1'b0};
        vecs[4] = '{1'b1, 4'hF, 32'h0000_0400, 32'h0000_0011, 1'b1, 4'hF, 32'h0000_0400, 32'h0000_0012, 0, 0, 32'h0,         1'b1};
        vecs[5] = '{1'b1, 4'h1, 32'h0000_0400, 32'h0000_0011, 1'b1, 4'h1, 32'h0000_0400, 32'h0000_0011, 0, 0, 32'h0,         1'b0};
        vecs[6] = '{1'b0, 4'hF, 32'h0000_0500, 32'hAAAA_0000, 1'b0, 4'hF, 32'h0000_0500, 32'h5555_0000, 0, 0, 32'hFEED_F00D, 1'b0};
        vecs[7] = '{1'b0, 4'hF, 32'h0000_0600, 32'h0,        1'b0, 4'hF, 32'h0000_0604, 32'h0,        0, 0, 32'h0,         1'b1};
        vecs[8] = '{1'b0, 4'hF, 32'h0000_0700, 32'h0,        1'b0, 4'hE, 32'h0000_0700, 32'h0,        2, 0, 32'h0,         1'b1};
        vecs[9] = '{1'b1, 4'hF, 32'h0000_0800, 32'h0,        1'b0, 4'hF, 32'h0000_0800, 32'h0,        0, 0, 32'h0,         1'b1};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_gnt_a", 64'(bus.a_gnt_o), 64'd0);
        chk("rst_mem_req", 64'(bus.mem_req_o), 64'd0);
        chk("rst_mem_addr", 64'(bus.mem_addr_o), 64'd0);
        chk("rst_mismatch", 64'(bus.mismatch_o), 64'd0);
        chk("rst_cause", 64'(bus.err_cause_o), 64'd0);
        chk("rst_count", 64'(bus.err_count_o), 64'd0);
        chk("rst_rdata", 64'(bus.rdata_o), 64'd0);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // B never arrives: timeout after SKEW_MAX cycles in HOLD.
        @(negedge clk);
        drive_a(vecs[0]);
        #1 chk("to_gnt_a", 64'(bus.a_gnt_o), 64'd1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            bus.a_req_i = 1'b0;
            #1 chk("to_hold_mismatch", 64'(bus.mismatch_o), 64'd0);
        end
        @(negedge clk);
        exp_cnt++;
        chk("to_mismatch", 64'(bus.mismatch_o), 64'd1);
        chk("to_cause", 64'(bus.err_cause_o), 64'd2);
        chk("to_count", 64'(bus.err_count_o), 64'(exp_cnt));
        chk("to_memreq", 64'(bus.mem_req_o), 64'd0);
        bus.b_req_i = 1'b1;
        #1 chk("to_gnt_b", 64'(bus.b_gnt_o), 64'd0);
        bus.b_req_i = 1'b0;
        @(negedge clk);
        chk("to_sticky", 64'(bus.mismatch_o), 64'd1);
        bus.clear_i = 1'b1;
        @(negedge clk);
        bus.clear_i = 1'b0;
        #1 chk("to_clr_cause", 64'(bus.err_cause_o), 64'd0);
        run_vec(vecs[0], 100);

        // Drive the error counter into saturation.
        for (int n = 0; n < 256; n++) run_vec(vecs[4], 200);
        chk("sat_count", 64'(bus.err_count_o), 64'hFF);

        // Reset while waiting for rvalid; the late rvalid must be ignored.
        @(negedge clk);
        drive_a(vecs[0]); drive_b(vecs[0]);
        @(negedge clk);
        bus.a_req_i = 1'b0; bus.b_req_i = 1'b0;
        @(negedge clk);
        chk("rr_memreq", 64'(bus.mem_req_o), 64'd1);
        bus.mem_gnt_i = 1'b1;
        @(negedge clk);
        bus.mem_gnt_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hCAFE_F00D;
        #1;
        chk("rr_rvalid_a", 64'(bus.a_rvalid_o), 64'd0);
        chk("rr_rvalid_b", 64'(bus.b_rvalid_o), 64'd0);
        chk("rr_rdata", 64'(bus.rdata_o), 64'd0);
        chk("rr_mem_addr", 64'(bus.mem_addr_o), 64'd0);
        chk("rr_count", 64'(bus.err_count_o), 64'd0);
        chk("rr_mismatch", 64'(bus.mismatch_o), 64'd0);
        @(negedge clk);
        bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;
        run_vec(vecs[0], 300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
